// File: rtl/mem_stream_sched.sv
// Shares the single RAM read port between never-stalled host reads and a credit-limited
// frame reader that streams cfg_frame_length words from cfg_base_addr as AXI-Stream frames.
module mem_stream_sched #(
    parameter int unsigned G_ADDRWIDTH = 10,
    parameter int unsigned G_DATAWIDTH = 32,
    parameter int unsigned G_WSTRB     = ((G_DATAWIDTH - 1) / 8) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h_rd,
    input  logic [G_ADDRWIDTH-1:0] h_raddr,
    output logic [G_DATAWIDTH-1:0] h_rdata,
    output logic                   h_rvalid,
    input  logic                   h_wr,
    input  logic [G_ADDRWIDTH-1:0] h_waddr,
    input  logic [G_DATAWIDTH-1:0] h_wdata,
    input  logic [G_WSTRB-1:0]     h_wstrb,
    output logic                   rd,
    output logic [G_ADDRWIDTH-1:0] raddr,
    input  logic [G_DATAWIDTH-1:0] rdata,
    input  logic                   rvalid,
    output logic                   wr,
    output logic [G_ADDRWIDTH-1:0] waddr,
    output logic [G_DATAWIDTH-1:0] wdata,
    output logic [G_WSTRB-1:0]     wstrb,
    input  logic                   cfg_enable,
    input  logic [G_ADDRWIDTH-1:0] cfg_base_addr,
    input  logic [7:0]             cfg_frame_length,
    output logic [G_DATAWIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [G_ADDRWIDTH-1:0] base_q, base_d;
    logic [7:0]             len_m1_q, len_m1_d;
    logic [7:0]             idx_q, idx_d;
    logic                   frame_done_q, frame_done_d;

    // Owner FIFO entry: {stream_owned, last_of_frame}
    logic [1:0]             own_mem_q [8];
    logic [1:0]             own_mem_d [8];
    logic [2:0]             own_wp_q, own_wp_d, own_rp_q, own_rp_d;
    logic [3:0]             own_cnt_q, own_cnt_d;
    logic [2:0]             sif_q, sif_d;

    // Output FIFO entry: {last, data}
    logic [G_DATAWIDTH:0]   of_mem_q [4];
    logic [G_DATAWIDTH:0]   of_mem_d [4];
    logic [1:0]             of_wp_q, of_wp_d, of_rp_q, of_rp_d;
    logic [2:0]             of_cnt_q, of_cnt_d;

    logic                   credit_ok, stream_rd, is_last_rd;
    logic                   own_pop, host_ret, strm_ret, beat, last_beat;
    logic [1:0]             own_head;
    logic [G_DATAWIDTH:0]   of_head;

    assign wr    = h_wr;
    assign waddr = h_waddr;
    assign wdata = h_wdata;
    assign wstrb = h_wstrb;

    always_comb begin
        credit_ok  = ({1'b0, sif_q} + {1'b0, of_cnt_q}) < 4'd4;
        stream_rd  = !h_rd && (state_q == StStream) && credit_ok;
        is_last_rd = (idx_q == len_m1_q);
        rd         = h_rd || stream_rd;
        raddr      = '0;
        if (h_rd) begin
            raddr = h_raddr;
        end else if (stream_rd) begin
            raddr = base_q + G_ADDRWIDTH'(idx_q);
        end

        own_head = own_mem_q[own_rp_q];
        own_pop  = rvalid && (own_cnt_q != 4'd0);
        host_ret = own_pop && !own_head[1];
        strm_ret = own_pop && own_head[1];
        h_rvalid = host_ret;
        h_rdata  = host_ret ? rdata : '0;

        of_head       = of_mem_q[of_rp_q];
        m_axis_tvalid = (of_cnt_q != 3'd0);
        m_axis_tdata  = m_axis_tvalid ? of_head[G_DATAWIDTH-1:0] : '0;
        m_axis_tlast  = m_axis_tvalid && of_head[G_DATAWIDTH];
        beat          = m_axis_tvalid && m_axis_tready;
        last_beat     = beat && m_axis_tlast;

        busy       = (state_q != StIdle);
        frame_done = frame_done_q;
    end

    always_comb begin
        own_mem_d = own_mem_q;
        if (rd) begin
            own_mem_d[own_wp_q] = {stream_rd, stream_rd && is_last_rd};
        end
        own_wp_d  = rd ? own_wp_q + 3'd1 : own_wp_q;
        own_rp_d  = own_pop ? own_rp_q + 3'd1 : own_rp_q;
        own_cnt_d = own_cnt_q;
        if (rd && !own_pop) begin
            own_cnt_d = own_cnt_q + 4'd1;
        end else if (!rd && own_pop) begin
            own_cnt_d = own_cnt_q - 4'd1;
        end

        sif_d = sif_q;
        if (stream_rd && !strm_ret) begin
            sif_d = sif_q + 3'd1;
        end else if (!stream_rd && strm_ret) begin
            sif_d = sif_q - 3'd1;
        end

        of_mem_d = of_mem_q;
        if (strm_ret) begin
            of_mem_d[of_wp_q] = {own_head[0], rdata};
        end
        of_wp_d  = strm_ret ? of_wp_q + 2'd1 : of_wp_q;
        of_rp_d  = beat ? of_rp_q + 2'd1 : of_rp_q;
        of_cnt_d = of_cnt_q;
        if (strm_ret && !beat) begin
            of_cnt_d = of_cnt_q + 3'd1;
        end else if (!strm_ret && beat) begin
            of_cnt_d = of_cnt_q - 3'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_m1_d     = len_m1_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_enable) begin
                    base_d   = cfg_base_addr;
                    len_m1_d = cfg_frame_length - 8'd1;  // length 0 wraps to 255, i.e. 256 words
                    idx_d    = 8'd0;
                    state_d  = StStream;
                end
            end
            StStream: begin
                if (stream_rd) begin
                    idx_d = idx_q + 8'd1;
                    if (is_last_rd) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_beat) begin
                    frame_done_d = 1'b1;
                    if (cfg_enable) begin
                        base_d   = cfg_base_addr;
                        len_m1_d = cfg_frame_length - 8'd1;
                        idx_d    = 8'd0;
                        state_d  = StStream;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            len_m1_q     <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            own_wp_q     <= '0;
            own_rp_q     <= '0;
            own_cnt_q    <= '0;
            sif_q        <= '0;
            of_wp_q      <= '0;
            of_rp_q      <= '0;
            of_cnt_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                own_mem_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                of_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_m1_q     <= len_m1_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            own_wp_q     <= own_wp_d;
            own_rp_q     <= own_rp_d;
            own_cnt_q    <= own_cnt_d;
            sif_q        <= sif_d;
            of_wp_q      <= of_wp_d;
            of_rp_q      <= of_rp_d;
            of_cnt_q     <= of_cnt_d;
            own_mem_q    <= own_mem_d;
            of_mem_q     <= of_mem_d;
        end
    end

endmodule

// File: tb/tb_mem_stream_sched.sv
// Directed bench for mem_stream_sched with a 1-cycle-latency RAM model and a negedge monitor.
module tb_mem_stream_sched;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          h_rd = 1'b0;
    logic [AW-1:0] h_raddr = '0;
    logic [DW-1:0] h_rdata;
    logic          h_rvalid;
    logic          h_wr = 1'b0;
    logic [AW-1:0] h_waddr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic [SW-1:0] h_wstrb = '0;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          cfg_enable = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [7:0]    cfg_frame_length = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          busy;
    logic          frame_done;

    logic [DW-1:0] mem [1024];
    logic          ram_rvalid = 1'b0;
    logic [DW-1:0] ram_rdata = '0;
    logic          inj_rvalid = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_stream_sched dut (
        .clk              (clk),
        .rst              (rst),
        .h_rd             (h_rd),
        .h_raddr          (h_raddr),
        .h_rdata          (h_rdata),
        .h_rvalid         (h_rvalid),
        .h_wr             (h_wr),
        .h_waddr          (h_waddr),
        .h_wdata          (h_wdata),
        .h_wstrb          (h_wstrb),
        .rd               (rd),
        .raddr            (raddr),
        .rdata            (rdata),
        .rvalid           (rvalid),
        .wr               (wr),
        .waddr            (waddr),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .cfg_enable       (cfg_enable),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_frame_length (cfg_frame_length),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    assign rvalid = ram_rvalid | inj_rvalid;
    assign rdata  = inj_rvalid ? 32'h5555_AAAA : ram_rdata;

    // RAM model: one-cycle read latency, byte-strobed writes.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ram_rvalid <= rd;
        if (rd) ram_rdata <= mem[raddr];
        if (wr) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic          clr_req = 1'b0;
    logic [DW-1:0] beat_d [$];
    bit            beat_l [$];
    int            acc_cyc [$];
    logic [AW-1:0] srd_addr [$];
    int            srd_cyc [$];
    logic [DW-1:0] hret_d [$];
    int            hret_cyc [$];
    int            hrd_cyc [$];
    int            fd_cyc [$];
    int            first_tv = -1;
    int            out_cnt = 0;
    int            max_out = 0;

    always @(negedge clk) begin
        if (clr_req) begin
            beat_d.delete(); beat_l.delete(); acc_cyc.delete();
            srd_addr.delete(); srd_cyc.delete();
            hret_d.delete(); hret_cyc.delete(); hrd_cyc.delete(); fd_cyc.delete();
            first_tv = -1; out_cnt = 0; max_out = 0;
        end else begin
            if (rd && !h_rd) begin
                srd_addr.push_back(raddr); srd_cyc.push_back(cyc); out_cnt++;
            end
            if (out_cnt > max_out) max_out = out_cnt;
            if (h_rd) hrd_cyc.push_back(cyc);
            if (h_rvalid) begin hret_d.push_back(h_rdata); hret_cyc.push_back(cyc); end
            if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_d.push_back(m_axis_tdata); beat_l.push_back(m_axis_tlast);
                acc_cyc.push_back(cyc); out_cnt--;
            end
            if (frame_done) fd_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        @(negedge clk); #1;
        clr_req = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        do begin step(); n++; end while ((busy || m_axis_tvalid) && n < budget);
        timed_out = busy || m_axis_tvalid;
        repeat (2) step();
    endtask

    task automatic preload();
        logic [DW-1:0] d [$];
        logic [AW-1:0] a [$];
        for (int i = 0; i < 4; i++) begin a.push_back(AW'(16 + i)); d.push_back(32'hA000_0000 + 32'(i)); end
        for (int i = 0; i < 8; i++) begin a.push_back(AW'(32 + i)); d.push_back(32'hB000_0000 + 32'(i)); end
        for (int i = 0; i < 2; i++) begin a.push_back(AW'(48 + i)); d.push_back(32'hF000_0000 + 32'(i)); end
        for (int i = 0; i < 12; i++) begin a.push_back(AW'(64 + i)); d.push_back(32'hC000_0000 + 32'(i)); end
        for (int i = 0; i < 256; i++) begin a.push_back(AW'(256 + i)); d.push_back(32'hE000_0000 + 32'(i)); end
        a.push_back(10'h200); d.push_back(32'hDEAD_0200);
        a.push_back(10'h3FE); d.push_back(32'hD000_0000);
        a.push_back(10'h3FF); d.push_back(32'hD000_0001);
        a.push_back(10'h000); d.push_back(32'hD000_0002);
        for (int i = 0; i < a.size(); i++) begin
            step(); h_wr = 1'b1; h_waddr = a[i]; h_wdata = d[i]; h_wstrb = 4'hF;
        end
        step(); h_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", rd); end
        checks++; if (raddr !== '0) begin errors++; $display("FAIL reset_raddr: got %h want 0", raddr); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL reset_h_rvalid: got %b want 0", h_rvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int c0; bit to; logic [DW-1:0] e;
        clear_mon();
        cfg_base_addr = 10'h010; cfg_frame_length = 8'd4; cfg_enable = 1'b1; c0 = cyc;
        step(); cfg_enable = 1'b0;
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: busy=%b tvalid=%b want idle", busy, m_axis_tvalid); end
        checks++; if (srd_cyc.size() < 1 || srd_cyc[0] != c0 + 1 || srd_addr[0] !== 10'h010) begin
            errors++; $display("FAIL basic_first_rd: reads=%0d want first rd at cycle %0d addr 010", srd_cyc.size(), c0 + 1);
        end
        checks++; if (first_tv != c0 + 3) begin errors++; $display("FAIL basic_first_tvalid: got cycle %0d want %0d", first_tv, c0 + 3); end
        checks++;
        if (beat_d.size() != 4) begin errors++; $display("FAIL basic_beat_count: got %0d want 4", beat_d.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                e = 32'hA000_0000 + 32'(i);
                checks++;
                if (beat_d[i] !== e || beat_l[i] !== (i == 3)) begin
                    errors++; $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, beat_d[i], beat_l[i], e, i == 3);
                end
            end
            checks++; if (acc_cyc[3] - acc_cyc[0] != 3) begin errors++; $display("FAIL basic_throughput: got span %0d want 3", acc_cyc[3] - acc_cyc[0]); end
            checks++; if (fd_cyc.size() != 1 || fd_cyc[0] != acc_cyc[3] + 1) begin
                errors++; $display("FAIL basic_frame_done: pulses=%0d want 1 at cycle %0d", fd_cyc.size(), acc_cyc[3] + 1);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_concurrent_write();
        bit to;
        clear_mon();
        cfg_base_addr = 10'h010; cfg_frame_length = 8'd4; cfg_enable = 1'b1;
        step(); cfg_enable = 1'b0;
        h_wr = 1'b1; h_waddr = 10'h011; h_wdata = 32'h1234_5678; h_wstrb = 4'b0101;
        #1;
        checks++; if (wr !== 1'b1 || waddr !== 10'h011) begin errors++; $display("FAIL write_wr_addr: got %b/%h want 1/011", wr, waddr); end
        checks++; if (wdata !== 32'h1234_5678 || wstrb !== 4'b0101) begin errors++; $display("FAIL write_data_strb: got %h/%b want 12345678/0101", wdata, wstrb); end
        checks++; if (rd !== 1'b1 || raddr !== 10'h010) begin errors++; $display("FAIL write_stream_rd: got %b/%h want 1/010", rd, raddr); end
        step(); h_wr = 1'b0;
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL write_timeout: busy=%b want 0", busy); end
        checks++; if (beat_d.size() != 4 || beat_d[1] !== 32'hA034_0078 || beat_d[0] !== 32'hA000_0000) begin
            errors++; $display("FAIL write_merged_beat: beats=%0d want 4 with beat1 A0340078", beat_d.size());
        end
        step(); h_wr = 1'b1; h_waddr = 10'h011; h_wdata = 32'hA000_0001; h_wstrb = 4'hF;
        step(); h_wr = 1'b0;
    endtask

    task automatic test_host_priority();
        bit to; logic [DW-1:0] e;
        clear_mon();
        cfg_base_addr = 10'h020; cfg_frame_length = 8'd8; cfg_enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(); cfg_enable = 1'b0;
            h_rd = (k % 2 == 0); h_raddr = 10'h200;
            #1;
            if (h_rd) begin
                checks++; if (rd !== 1'b1 || raddr !== 10'h200) begin errors++; $display("FAIL host_wins_%0d: got %b/%h want 1/200", k, rd, raddr); end
            end
        end
        step(); h_rd = 1'b0;
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL host_timeout: busy=%b want 0", busy); end
        checks++;
        if (hret_d.size() != 8 || hrd_cyc.size() != 8) begin
            errors++; $display("FAIL host_return_count: got %0d want 8", hret_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (hret_d[i] !== 32'hDEAD_0200 || hret_cyc[i] != hrd_cyc[i] + 1) begin
                    errors++; $display("FAIL host_return%0d: got %h at %0d want DEAD0200 at %0d", i, hret_d[i], hret_cyc[i], hrd_cyc[i] + 1);
                end
            end
        end
        checks++;
        if (beat_d.size() != 8) begin errors++; $display("FAIL host_beat_count: got %0d want 8", beat_d.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                e = 32'hB000_0000 + 32'(i);
                checks++;
                if (beat_d[i] !== e || beat_l[i] !== (i == 7)) begin
                    errors++; $display("FAIL host_beat%0d: got %h/%b want %h/%b", i, beat_d[i], beat_l[i], e, i == 7);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int phase = 0; int hold = 0; bit stall_bad = 1'b0; logic [DW-1:0] ref_d = '0; logic [DW-1:0] e;
        clear_mon();
        cfg_base_addr = 10'h040; cfg_frame_length = 8'd12; cfg_enable = 1'b1;
        step(); cfg_enable = 1'b0;
        for (int n = 0; n < 300 && phase != 3; n++) begin
            step();
            case (phase)
                0: if (beat_d.size() >= 3) begin m_axis_tready = 1'b0; phase = 1; end
                1: begin
                    if (hold == 0) ref_d = m_axis_tdata;
                    else if (m_axis_tdata !== ref_d || m_axis_tvalid !== 1'b1) stall_bad = 1'b1;
                    hold++;
                    if (hold == 20) begin m_axis_tready = 1'b1; phase = 2; end
                end
                default: if (!busy && !m_axis_tvalid) phase = 3;
            endcase
        end
        m_axis_tready = 1'b1;
        checks++; if (phase != 3) begin errors++; $display("FAIL bp_timeout: phase %0d want 3", phase); end
        checks++; if (stall_bad) begin errors++; $display("FAIL bp_tdata_stable: tdata changed from %h while stalled", ref_d); end
        checks++; if (max_out != 4) begin errors++; $display("FAIL bp_outstanding: got max %0d want 4", max_out); end
        checks++;
        if (beat_d.size() != 12) begin errors++; $display("FAIL bp_beat_count: got %0d want 12", beat_d.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                e = 32'hC000_0000 + 32'(i);
                checks++;
                if (beat_d[i] !== e || beat_l[i] !== (i == 11)) begin
                    errors++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, beat_d[i], beat_l[i], e, i == 11);
                end
            end
        end
        repeat (2) step();
    endtask

    task automatic test_wrap();
        bit to; logic [AW-1:0] ea [3]; logic [DW-1:0] e;
        ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000;
        clear_mon();
        cfg_base_addr = 10'h3FE; cfg_frame_length = 8'd3; cfg_enable = 1'b1;
        step(); cfg_enable = 1'b0;
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout: busy=%b want 0", busy); end
        checks++;
        if (srd_addr.size() != 3 || beat_d.size() != 3) begin
            errors++; $display("FAIL wrap_count: reads=%0d beats=%0d want 3/3", srd_addr.size(), beat_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = 32'hD000_0000 + 32'(i);
                checks++;
                if (srd_addr[i] !== ea[i] || beat_d[i] !== e || beat_l[i] !== (i == 2)) begin
                    errors++; $display("FAIL wrap_beat%0d: got %h %h/%b want %h %h/%b", i, srd_addr[i], beat_d[i], beat_l[i], ea[i], e, i == 2);
                end
            end
        end
    endtask

    task automatic test_len0();
        bit to; int bad_d = 0; int bad_l = 0;
        clear_mon();
        cfg_base_addr = 10'h100; cfg_frame_length = 8'd0; cfg_enable = 1'b1;
        step(); cfg_enable = 1'b0;
        wait_idle(700, to);
        checks++; if (to) begin errors++; $display("FAIL len0_timeout: busy=%b want 0", busy); end
        checks++;
        if (beat_d.size() != 256) begin errors++; $display("FAIL len0_beat_count: got %0d want 256", beat_d.size()); end
        else begin
            for (int i = 0; i < 256; i++) begin
                if (beat_d[i] !== 32'hE000_0000 + 32'(i)) bad_d++;
                if (beat_l[i] !== (i == 255)) bad_l++;
            end
            checks++; if (bad_d != 0) begin errors++; $display("FAIL len0_data: got %0d wrong beats want 0", bad_d); end
            checks++; if (bad_l != 0) begin errors++; $display("FAIL len0_tlast: got %0d wrong flags want 0", bad_l); end
        end
        checks++; if (fd_cyc.size() != 1) begin errors++; $display("FAIL len0_frame_done: got %0d pulses want 1", fd_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        bit to; logic [AW-1:0] ea [4]; logic [DW-1:0] ed [4];
        ea[0] = 10'h010; ea[1] = 10'h011; ea[2] = 10'h030; ea[3] = 10'h031;
        ed[0] = 32'hA000_0000; ed[1] = 32'hA000_0001; ed[2] = 32'hF000_0000; ed[3] = 32'hF000_0001;
        clear_mon();
        cfg_base_addr = 10'h010; cfg_frame_length = 8'd2; cfg_enable = 1'b1;
        step(); cfg_base_addr = 10'h030;
        for (int n = 0; n < 100 && fd_cyc.size() == 0; n++) step();
        cfg_enable = 1'b0;
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: busy=%b want 0", busy); end
        checks++;
        if (srd_addr.size() != 4 || beat_d.size() != 4 || fd_cyc.size() != 2) begin
            errors++; $display("FAIL b2b_count: reads=%0d beats=%0d done=%0d want 4/4/2", srd_addr.size(), beat_d.size(), fd_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (srd_addr[i] !== ea[i] || beat_d[i] !== ed[i] || beat_l[i] !== (i % 2 == 1)) begin
                    errors++; $display("FAIL b2b_beat%0d: got %h %h/%b want %h %h/%b", i, srd_addr[i], beat_d[i], beat_l[i], ea[i], ed[i], i % 2 == 1);
                end
            end
            checks++; if (srd_cyc[2] != fd_cyc[0]) begin errors++; $display("FAIL b2b_boundary: got rd at %0d want %0d", srd_cyc[2], fd_cyc[0]); end
            checks++; if (fd_cyc[0] != acc_cyc[1] + 1) begin errors++; $display("FAIL b2b_done_timing: got %0d want %0d", fd_cyc[0], acc_cyc[1] + 1); end
        end
    endtask

    task automatic test_enable_drop();
        bit to; logic [DW-1:0] e;
        clear_mon();
        cfg_base_addr = 10'h040; cfg_frame_length = 8'd5; cfg_enable = 1'b1;
        for (int n = 0; n < 100 && beat_d.size() < 2; n++) step();
        cfg_enable = 1'b0;
        wait_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL drop_timeout: busy=%b want 0", busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
        checks++;
        if (beat_d.size() != 5 || fd_cyc.size() != 1) begin
            errors++; $display("FAIL drop_count: beats=%0d done=%0d want 5/1", beat_d.size(), fd_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                e = 32'hC000_0000 + 32'(i);
                checks++;
                if (beat_d[i] !== e || beat_l[i] !== (i == 4)) begin
                    errors++; $display("FAIL drop_beat%0d: got %h/%b want %h/%b", i, beat_d[i], beat_l[i], e, i == 4);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        cfg_base_addr = 10'h040; cfg_frame_length = 8'd8; cfg_enable = 1'b1;
        for (int n = 0; n < 100 && beat_d.size() < 2; n++) step();
        rst = 1'b1; cfg_enable = 1'b0;
        step(); rst = 1'b0; inj_rvalid = 1'b1;
        #1;
        checks++; if (rd !== 1'b0 || raddr !== '0) begin errors++; $display("FAIL rst_mid_rd: got %b/%h want 0/0", rd, raddr); end
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            errors++; $display("FAIL rst_mid_stream: got %b/%b/%h want 0/0/0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale_host: got %b want 0", h_rvalid); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b/%b want 0/0", busy, frame_done); end
        step(); inj_rvalid = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale_stream: got %b want 0", m_axis_tvalid); end
        repeat (3) step();
        checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || h_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet: got %b/%b/%b want 0/0/0", m_axis_tvalid, busy, h_rvalid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload();
        test_basic();
        test_concurrent_write();
        test_host_priority();
        test_backpressure();
        test_wrap();
        test_len0();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
